vmem_banked: RTL
================

Name: vmem_banked

Overview:
- Multi-ported, banked local vector memory; successor to the single-BRAM, 2-read/1-write memory attached to the vector datapath.
- Address space is split into NUM_BANKS low-order-interleaved banks, each serving one access per cycle.
- Any number of read and write ports issue valid/ready requests; a per-bank round-robin arbiter serialises conflicts.
- Read data returns with fixed 1-cycle latency after grant; a saturating counter records bank conflicts.

Parameters:
- DATA_WIDTH, 32, bits per word
- ADDR_WIDTH, 10, word address width (total depth 2**ADDR_WIDTH)
- NUM_BANKS, 4, power of two, 1..16; bank = addr[log2(NUM_BANKS)-1:0]
- NUM_RD_PORTS, 2, read ports (1..4)
- NUM_WR_PORTS, 2, write ports (1..4)
- CNT_WIDTH, 16, width of conflict counter

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- rd_valid  in  NUM_RD_PORTS  read request per port
- rd_addr  in  NUM_RD_PORTS*ADDR_WIDTH  packed read addresses, port 0 in LSBs
- rd_ready  out  NUM_RD_PORTS  request granted this cycle (combinational)
- rd_rvalid  out  NUM_RD_PORTS  read data valid, one cycle after grant
- rd_data  out  NUM_RD_PORTS*DATA_WIDTH  packed read data
- wr_valid  in  NUM_WR_PORTS  write request per port
- wr_addr  in  NUM_WR_PORTS*ADDR_WIDTH  packed write addresses
- wr_data  in  NUM_WR_PORTS*DATA_WIDTH  packed write data
- wr_ready  out  NUM_WR_PORTS  write accepted this cycle (combinational)
- busy  out  1  any request pending but not granted this cycle
- conflict_cnt  out  CNT_WIDTH  saturating count of cycles with at least one denied request
- conflict_clr  in  1  synchronous clear of conflict_cnt

Behaviour:
- Reset (rst=0, async): rd_rvalid=0, rd_data=0, conflict_cnt=0, all arbiter pointers=0. Memory contents not reset.
- Requester index per bank: write ports 0..NUM_WR_PORTS-1, then read ports NUM_WR_PORTS..NUM_WR_PORTS+NUM_RD_PORTS-1.
- Per bank, per cycle: among requesters whose address maps to that bank, grant exactly one by round-robin starting at that bank's pointer.
- After a grant, the pointer moves to winner+1 mod total requesters. With no grant, the pointer holds.
- rd_ready/wr_ready are combinational from valid/addr/pointers and contain no combinational path from ready to valid.
- A requester holds valid and addr/data stable until ready. Dropping valid before ready is legal; the request is lost and there is no side effect.
- Write: on the grant edge, bank[addr >> log2(NUM_BANKS)] <= data.
- Read: on the grant edge the bank word is registered into rd_data slot p, and rd_rvalid[p]=1 the following cycle for exactly one cycle. rd_data holds its last value when rd_rvalid=0.
- Same-address read and write in the same cycle always share a bank and are serialised. The later-granted access sees the earlier one's effect (no read-during-write hazard exists).
- Different banks proceed fully in parallel. Up to min(NUM_BANKS, total ports) grants per cycle.
- busy = OR over ports of (valid & ~ready).
- conflict_cnt increments on cycles where busy=1 and saturates at all-ones. conflict_clr takes priority over increment.
- NUM_BANKS=1 degenerates to a single round-robin-arbitrated memory.

Decomposition:
- Package vmem_pkg holds:
  - log2/bitwidth functions
  - BANK_BITS = log2(NUM_BANKS)
  - bank-index and row-index extraction functions
  - requester-index ordering constants
- Sub-module rr_arbiter, parametrised by N, with inputs req[N], adv, rst, clk and output one-hot gnt[N]. It holds the rotating pointer and is instanced once per bank.
- Bank storage is an inferred array per bank inside vmem_banked.

Test Plan:
1. Reset/basic path: write port 0 writes addr 0x005 <= 0xDEADBEEF, then read port 0 reads 0x005. Expect wr_ready=1 same cycle, rd_rvalid=1 one cycle after rd_ready, rd_data=0xDEADBEEF, busy=0.
2. Parallel banks: all 4 ports hit addrs 0x000, 0x001, 0x002, 0x003 in one cycle. Expect all ready=1, conflict_cnt unchanged.
3. Bank conflict fairness: rd0 and rd1 both hold valid to bank 2 (0x006, 0x00A) for 4 cycles with the pointer at 0. Expect grants to alternate rd0, rd1, rd0, rd1, busy=1 each cycle, and conflict_cnt=4 afterwards.
4. Same-address ordering: wr0 writes 0x010 <= 0x1234 while rd0 reads 0x010, with the old value 0x0. Write (index 0) wins first and rd0 is granted next cycle, returning 0x1234.
5. Counter saturation/clear: with CNT_WIDTH=4, force 20 conflict cycles and expect conflict_cnt=0xF. Assert conflict_clr with a concurrent conflict and expect 0.
6. Async reset mid-operation: drop rst between a read grant and rd_rvalid. Expect rd_rvalid=0 immediately and no spurious rvalid after release. A prior write persists: a read of that address after reset returns the written value.

Source files
------------

// File: rtl/vmem_pkg.sv
// Shared helpers for the banked vector memory: width arithmetic, address
// splitting into bank/row, and the fixed ordering of requesters seen by
// every bank arbiter.
package vmem_pkg;

    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_ADDR_WIDTH   = 10;
    localparam int DEF_NUM_BANKS    = 4;
    localparam int DEF_NUM_RD_PORTS = 2;
    localparam int DEF_NUM_WR_PORTS = 2;
    localparam int DEF_CNT_WIDTH    = 16;

    // Ceiling log2; exact for the power-of-two bank counts used here.
    function automatic int vmem_log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Bits needed to index n items, never less than one.
    function automatic int vmem_bits(input int n);
        return (n <= 2) ? 1 : vmem_log2(n);
    endfunction

    localparam int BANK_BITS = vmem_log2(DEF_NUM_BANKS);

    // Low-order interleave: the bottom bank_bits address bits pick the bank.
    function automatic int bank_of(input logic [31:0] addr, input int bank_bits);
        return int'(addr & ((32'd1 << bank_bits) - 32'd1));
    endfunction

    // The remaining upper address bits pick the word inside the bank.
    function automatic int row_of(input logic [31:0] addr, input int bank_bits);
        return int'(addr >> bank_bits);
    endfunction

    // Write ports take the lowest requester indices, read ports follow.
    function automatic int wr_req_index(input int p);
        return p;
    endfunction

    function automatic int rd_req_index(input int p, input int num_wr);
        return num_wr + p;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for one bank. Grants the first active request found
// scanning upward from the pointer; the pointer then moves past the winner.
module rr_arbiter
    import vmem_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         adv,
    output logic [N-1:0] gnt
);

    localparam int PW = vmem_bits(N);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] win;
    logic [PW-1:0] cand_idx;
    logic          found;
    int            cand;

    // Wrap-around scan from the pointer; first active request wins.
    always_comb begin
        gnt      = '0;
        found    = 1'b0;
        win      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= N) cand = cand - N;
            cand_idx = PW'(cand);
            if (!found && req[cand_idx]) begin
                found         = 1'b1;
                win           = cand_idx;
                gnt[cand_idx] = 1'b1;
            end
        end
    end

    // Pointer moves to winner+1 only when a grant is actually taken.
    always_comb begin
        ptr_d = ptr_q;
        if (adv && found) begin
            ptr_d = (int'(win) == N - 1) ? '0 : win + 1'b1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= '0;
        else      ptr_q <= ptr_d;
    end

endmodule

// File: rtl/vmem_banked.sv
// Banked multi-port local vector memory. Each bank is a single-port array
// serving one write or one registered read per cycle; a per-bank round-robin
// arbiter picks among the ports addressing it. Read data returns one cycle
// after the grant and is held in a per-port register afterwards.
module vmem_banked
    import vmem_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int NUM_BANKS    = 4,
    parameter int NUM_RD_PORTS = 2,
    parameter int NUM_WR_PORTS = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_RD_PORTS-1:0]            rd_valid,
    input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD_PORTS-1:0]            rd_ready,
    output logic [NUM_RD_PORTS-1:0]            rd_rvalid,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data,
    input  logic [NUM_WR_PORTS-1:0]            wr_valid,
    input  logic [NUM_WR_PORTS*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_WR_PORTS*DATA_WIDTH-1:0] wr_data,
    output logic [NUM_WR_PORTS-1:0]            wr_ready,
    output logic                               busy,
    output logic [CNT_WIDTH-1:0]               conflict_cnt,
    input  logic                               conflict_clr
);

    localparam int BANK_W  = vmem_log2(NUM_BANKS);
    localparam int NUM_REQ = NUM_WR_PORTS + NUM_RD_PORTS;
    localparam int ROW_W   = ADDR_WIDTH - BANK_W;
    localparam int ROWS    = 1 << ROW_W;
    localparam int BSEL_W  = vmem_bits(NUM_BANKS);

    // Unified requester view shared by every bank arbiter.
    logic [NUM_REQ-1:0]    req_valid;
    logic [ADDR_WIDTH-1:0] req_addr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] req_wdata [NUM_REQ];
    logic [NUM_REQ-1:0]    req_ready;

    logic [NUM_BANKS-1:0][NUM_REQ-1:0]    gnt_all;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] rdata_all;

    for (genvar gi = 0; gi < NUM_WR_PORTS; gi++) begin : g_wr_map
        assign req_valid[wr_req_index(gi)] = wr_valid[gi];
        assign req_addr[wr_req_index(gi)]  = wr_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign req_wdata[wr_req_index(gi)] = wr_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    for (genvar gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_rd_map
        assign req_valid[rd_req_index(gi, NUM_WR_PORTS)] = rd_valid[gi];
        assign req_addr[rd_req_index(gi, NUM_WR_PORTS)]  = rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign req_wdata[rd_req_index(gi, NUM_WR_PORTS)] = '0;
    end

    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        logic [NUM_REQ-1:0]    req;
        logic [NUM_REQ-1:0]    gnt;
        logic                  wr_en;
        logic                  rd_en;
        logic [ROW_W-1:0]      row;
        logic [DATA_WIDTH-1:0] wr_word;
        logic [DATA_WIDTH-1:0] mem [ROWS];
        logic [DATA_WIDTH-1:0] rdata;

        // Requests whose address interleaves onto this bank.
        always_comb begin
            req = '0;
            for (int r = 0; r < NUM_REQ; r++) begin
                req[r] = req_valid[r] && (bank_of(32'(req_addr[r]), BANK_W) == gi);
            end
        end

        rr_arbiter #(.N(NUM_REQ)) u_arb (
            .clk (clk),
            .rst (rst),
            .req (req),
            .adv (|req),
            .gnt (gnt)
        );

        // Turn the one-hot grant into a single bank operation.
        always_comb begin
            wr_en   = 1'b0;
            rd_en   = 1'b0;
            row     = '0;
            wr_word = '0;
            for (int r = 0; r < NUM_REQ; r++) begin
                if (gnt[r]) begin
                    row = ROW_W'(row_of(32'(req_addr[r]), BANK_W));
                    if (r < NUM_WR_PORTS) begin
                        wr_en   = 1'b1;
                        wr_word = req_wdata[r];
                    end else begin
                        rd_en = 1'b1;
                    end
                end
            end
        end

        // Single-port bank storage with registered read; contents never reset.
        always_ff @(posedge clk) begin
            if (wr_en) mem[row] <= wr_word;
            if (rd_en) rdata <= mem[row];
        end

        assign gnt_all[gi]   = gnt;
        assign rdata_all[gi] = rdata;
    end

    // Each requester maps to exactly one bank, so OR-ing grants gives ready.
    always_comb begin
        req_ready = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            req_ready = req_ready | gnt_all[b];
        end
    end

    assign wr_ready = req_ready[NUM_WR_PORTS-1:0];
    assign rd_ready = req_ready[NUM_REQ-1:NUM_WR_PORTS];
    assign busy     = |(req_valid & ~req_ready);

    logic [NUM_RD_PORTS-1:0]                  rvalid_q, rvalid_d;
    logic [NUM_RD_PORTS-1:0][BSEL_W-1:0]      rbank_q, rbank_d;
    logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0]  rhold_q, rhold_d;
    logic [CNT_WIDTH-1:0]                     cnt_q, cnt_d;

    // Remember which bank each granted read came from; latch the returned
    // word so rd_data keeps it once rvalid drops.
    always_comb begin
        rvalid_d = rd_ready;
        rbank_d  = rbank_q;
        rhold_d  = rhold_q;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            if (rd_ready[p]) begin
                rbank_d[p] = BSEL_W'(bank_of(32'(rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]), BANK_W));
            end
            if (rvalid_q[p]) begin
                rhold_d[p] = rdata_all[rbank_q[p]];
            end
        end
    end

    // Returned word comes straight from the bank register while valid.
    always_comb begin
        rd_data = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            rd_data[p*DATA_WIDTH +: DATA_WIDTH] = rvalid_q[p] ? rdata_all[rbank_q[p]] : rhold_q[p];
        end
    end

    assign rd_rvalid = rvalid_q;

    // Saturating conflict counter; clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (conflict_clr) begin
            cnt_d = '0;
        end else if (busy && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign conflict_cnt = cnt_q;

    // Read-return and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid_q <= '0;
            rbank_q  <= '0;
            rhold_q  <= '0;
            cnt_q    <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rbank_q  <= rbank_d;
            rhold_q  <= rhold_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
